j_gpuram_arb: RTL and testbench



---
 rtl/j_gpuram_arb.sv | 120 ++++++++++++
 tb/tb_j_gpuram_arb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/j_gpuram_arb.sv
// Two-port arbiter sharing the GPU's single-port 1024x32 RAM between GPU core and host bus.
// Define GPURAM_ARB_RR_EN for round-robin contention; default is GPU priority bounded by GPU_BURST.
module j_gpuram_arb #(
  parameter int GPU_BURST = 4
) (
  input  logic        sys_clk,
  input  logic        resetl,
  input  logic        g_req,
  input  logic        g_we,
  input  logic [9:0]  g_addr,
  input  logic [31:0] g_wdata,
  output logic        g_ack,
  output logic [31:0] g_rdata,
  output logic        g_rvalid,
  input  logic        h_req,
  input  logic        h_we,
  input  logic [9:0]  h_addr,
  input  logic [31:0] h_wdata,
  output logic        h_ack,
  output logic [31:0] h_rdata,
  output logic        h_rvalid,
  output logic [9:0]  rama,
  output logic        ramen,
  output logic        ramwe,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  // state | meaning
  // IDLE  | no RAM cycle this clock
  // GPU   | current RAM cycle belongs to the GPU port
  // HOST  | current RAM cycle belongs to the host port
  typedef enum logic [1:0] {ST_IDLE, ST_GPU, ST_HOST} state_t;

  state_t      r_state;
  logic [3:0]  r_burst;
  logic        r_last_h;
  logic        r_rd1_g, r_rd1_h;
  logic        r_rvalid_g, r_rvalid_h;
  logic [31:0] r_rdata_g, r_rdata_h;
  logic [9:0]  r_rama;
  logic        r_ramwe;
  logic [31:0] r_ram_din;
  logic        w_gnt_g, w_gnt_h;

  always_comb begin
    w_gnt_g = 1'b0;
    w_gnt_h = 1'b0;
    if (g_req && h_req) begin
`ifdef GPURAM_ARB_RR_EN
      if (r_last_h) w_gnt_g = 1'b1;
      else          w_gnt_h = 1'b1;
`else
      if (r_burst < 4'(GPU_BURST)) w_gnt_g = 1'b1;
      else                         w_gnt_h = 1'b1;
`endif
    end else begin
      w_gnt_g = g_req;
      w_gnt_h = h_req;
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_state    <= ST_IDLE;
      r_burst    <= 4'd0;
      r_last_h   <= 1'b1;
      r_rd1_g    <= 1'b0;
      r_rd1_h    <= 1'b0;
      r_rvalid_g <= 1'b0;
      r_rvalid_h <= 1'b0;
      r_rdata_g  <= 32'd0;
      r_rdata_h  <= 32'd0;
      r_rama     <= 10'd0;
      r_ramwe    <= 1'b0;
      r_ram_din  <= 32'd0;
    end else begin
      r_rd1_g    <= 1'b0;
      r_rd1_h    <= 1'b0;
      r_ramwe    <= 1'b0;
      if (w_gnt_g) begin
        r_state   <= ST_GPU;
        r_rama    <= g_addr;
        r_ramwe   <= g_we;
        r_ram_din <= g_wdata;
        r_rd1_g   <= ~g_we;
        r_last_h  <= 1'b0;
      end else if (w_gnt_h) begin
        r_state   <= ST_HOST;
        r_rama    <= h_addr;
        r_ramwe   <= h_we;
        r_ram_din <= h_wdata;
        r_rd1_h   <= ~h_we;
        r_last_h  <= 1'b1;
      end else begin
        r_state   <= ST_IDLE;
      end
      // Burst length only matters while the host is actually waiting.
      if (!h_req || w_gnt_h)                r_burst <= 4'd0;
      else if (w_gnt_g && r_burst != 4'hF)  r_burst <= r_burst + 4'd1;
      r_rvalid_g <= r_rd1_g;
      r_rvalid_h <= r_rd1_h;
      if (r_rvalid_g) r_rdata_g <= ram_dout;
      if (r_rvalid_h) r_rdata_h <= ram_dout;
    end
  end

  assign g_ack    = (r_state == ST_GPU);
  assign h_ack    = (r_state == ST_HOST);
  assign ramen    = (r_state != ST_IDLE);
  assign ramwe    = r_ramwe;
  assign rama     = r_rama;
  assign ram_din  = r_ram_din;
  assign g_rvalid = r_rvalid_g;
  assign h_rvalid = r_rvalid_h;
  // RAM data arrives in the rvalid cycle; pass it through then hold it.
  assign g_rdata  = r_rvalid_g ? ram_dout : r_rdata_g;
  assign h_rdata  = r_rvalid_h ? ram_dout : r_rdata_h;

endmodule

// File: tb/tb_j_gpuram_arb.sv
// Directed bench for j_gpuram_arb with a behavioural synchronous RAM; follows GPURAM_ARB_RR_EN.
module tb_j_gpuram_arb;
  logic        sys_clk = 1'b0;
  logic        resetl;
  logic        g_req, g_we, h_req, h_we;
  logic [9:0]  g_addr, h_addr;
  logic [31:0] g_wdata, h_wdata;
  logic        g_ack, g_rvalid, h_ack, h_rvalid;
  logic [31:0] g_rdata, h_rdata;
  logic [9:0]  rama;
  logic        ramen, ramwe;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  int n_chk = 0;
  int n_err = 0;

  j_gpuram_arb #(.GPU_BURST(4)) dut (
    .sys_clk(sys_clk), .resetl(resetl),
    .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
    .g_ack(g_ack), .g_rdata(g_rdata), .g_rvalid(g_rvalid),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .rama(rama), .ramen(ramen), .ramwe(ramwe), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ramen) begin
      if (ramwe) mem[rama] <= ram_din;
      else       ram_dout <= mem[rama];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    step();
    pre_we = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_acks"},   {30'd0, g_ack, h_ack}, 32'd0);
    check({tag, "_rvalid"}, {30'd0, g_rvalid, h_rvalid}, 32'd0);
    check({tag, "_g_rdata"}, g_rdata, 32'd0);
    check({tag, "_h_rdata"}, h_rdata, 32'd0);
    check({tag, "_ramctl"}, {20'd0, rama, ramen, ramwe}, 32'd0);
    check({tag, "_ram_din"}, ram_din, 32'd0);
  endtask

  initial begin
    logic exp_g;
    logic prev_g, prev_h;
    logic first_g, seen_first, seen_rv;
    logic [31:0] rv_data;
    int   wait_n;
    logic rr_mode;
`ifdef GPURAM_ARB_RR_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    resetl = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0; ram_dout = '0;
    g_req = 0; g_we = 0; g_addr = '0; g_wdata = '0;
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    preload(10'h001, 32'hAAAA5555);
    preload(10'h002, 32'h5555AAAA);
    preload(10'h010, 32'h0BADF00D);
    check_idle_outputs("reset");
    resetl = 1'b1;
    step();
    check_idle_outputs("post_reset");

    // lone GPU write then read at the top address
    g_req = 1; g_we = 1; g_addr = 10'h3FF; g_wdata = 32'h12345678;
    step();
    g_req = 0;
    check("wr_ack", {31'd0, g_ack}, 32'd1);
    check("wr_ctl", {20'd0, rama, ramen, ramwe}, {20'd0, 10'h3FF, 2'b11});
    check("wr_din", ram_din, 32'h12345678);
    g_req = 1; g_we = 0;
    step();
    g_req = 0;
    check("rd_ack", {31'd0, g_ack}, 32'd1);
    check("rd_ctl", {20'd0, rama, ramen, ramwe}, {20'd0, 10'h3FF, 2'b10});
    check("rd_rvalid_n1", {31'd0, g_rvalid}, 32'd0);
    step();
    check("rd_rvalid", {30'd0, g_rvalid, h_rvalid}, 32'd2);
    check("rd_data", g_rdata, 32'h12345678);
    check("rd_ramoff", {30'd0, ramen, ramwe}, 32'd0);
    step();
    check("rd_hold", g_rdata, 32'h12345678);
    check("rd_rvalid_off", {31'd0, g_rvalid}, 32'd0);

    // continuous contention; last grant so far was GPU
    g_req = 1; g_we = 0; g_addr = 10'h002;
    h_req = 1; h_we = 0; h_addr = 10'h001;
    prev_g = 0; prev_h = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      exp_g = rr_mode ? (i % 2 == 1) : (i % 5 != 4);
      check("cont_ack", {30'd0, g_ack, h_ack}, {30'd0, exp_g, ~exp_g});
      check("cont_rvalid", {30'd0, g_rvalid, h_rvalid}, {30'd0, prev_g, prev_h});
      if (g_rvalid) check("cont_g_rdata", g_rdata, 32'h5555AAAA);
      if (h_rvalid) check("cont_h_rdata", h_rdata, 32'hAAAA5555);
      prev_g = exp_g; prev_h = ~exp_g;
    end
    g_req = 0; h_req = 0;
    step();
    step();

    // host write vs GPU read of one address in the same cycle
    g_req = 1; g_we = 0; g_addr = 10'h010;
    h_req = 1; h_we = 1; h_addr = 10'h010; h_wdata = 32'hDEADBEEF;
    seen_first = 0; first_g = 0; seen_rv = 0; rv_data = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (g_rvalid) begin seen_rv = 1; rv_data = g_rdata; end
      if (g_ack) begin
        g_req = 0;
        if (!seen_first) begin seen_first = 1; first_g = 1; end
      end
      if (h_ack) begin
        h_req = 0;
        if (!seen_first) begin seen_first = 1; first_g = 0; end
      end
    end
    g_req = 0; h_req = 0;
    check("wr_rd_first_g", {30'd0, seen_first, first_g}, {30'd0, 1'b1, ~rr_mode});
    check("wr_rd_seen_rv", {31'd0, seen_rv}, 32'd1);
    check("wr_rd_data", rv_data, rr_mode ? 32'hDEADBEEF : 32'h0BADF00D);
    step();

    // GPU streams alone, then host joins while GPU keeps requesting
    g_req = 1; g_we = 0; g_addr = 10'h002;
    for (int i = 0; i < 8; i++) begin
      step();
      check("solo_g_ack", {30'd0, g_ack, h_ack}, 32'd2);
    end
    h_req = 1; h_we = 0; h_addr = 10'h001;
    wait_n = 0;
    for (int i = 1; i <= 8 && wait_n == 0; i++) begin
      step();
      if (h_ack) wait_n = i;
    end
    h_req = 0;
    check("host_wait", wait_n, rr_mode ? 32'd1 : 32'd5);
    g_req = 0;
    step();
    h_req = 1;
    step();
    h_req = 0;
    check("host_solo_ack", {30'd0, g_ack, h_ack}, 32'd1);
    step();
    check("host_solo_data", h_rdata, 32'hAAAA5555);
    step();

    // reset pulse in the cycle after a host read ack
    h_req = 1; h_we = 0; h_addr = 10'h001;
    step();
    h_req = 0;
    check("rst_pre_ack", {31'd0, h_ack}, 32'd1);
    #2 resetl = 1'b0;
    #1 check_idle_outputs("rst_async");
    #1 resetl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle_outputs("rst_after");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
